// File: rtl/vend_sequencer.sv
// Coin-operated vend sequencer: credit accounting, round-robin product grant to a
// shared dispenser, refund/timeout change payout.
//
// state  | meaning
// IDLE   | no credit, waiting for the first coin
// CREDIT | holding credit, accepting coins, arbitrating requests, timing out
// GRANT  | dispense request outstanding, waiting for disp_ack
// CHANGE | paying out one change pulse per cycle until credit is zero
module vend_sequencer #(
  parameter int PRICE      = 3,
  parameter int CREDIT_MAX = 15,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin,
  input  logic [3:0] sel,
  input  logic [3:0] sold_out,
  input  logic       refund,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic [1:0] disp_id,
  output logic       change,
  output logic       coin_reject,
  output logic [3:0] credit
);

  localparam logic [3:0] PRICE_L = 4'(PRICE);
  localparam logic [3:0] MAX_L   = 4'(CREDIT_MAX);
  localparam logic [7:0] TMO_L   = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CREDIT, GRANT, CHANGE} state_t;

  state_t     state_q, state_d;
  logic [3:0] credit_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] tmr_q, tmr_d;
  logic       disp_req_d, change_d, coin_reject_d;
  logic [1:0] disp_id_d;

  logic [3:0] elig;
  logic [1:0] idx, winner;
  logic       found;
  logic       grant;
  logic [3:0] cr;

  assign elig = sel & ~sold_out;

  // Descending scan so the requester closest to ptr is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit;
    ptr_d         = ptr_q;
    tmr_d         = tmr_q;
    disp_req_d    = disp_req;
    disp_id_d     = disp_id;
    change_d      = 1'b0;
    coin_reject_d = 1'b0;
    grant         = 1'b0;
    cr            = credit;
    case (state_q)
      IDLE: begin
        if (coin) begin
          state_d  = CREDIT;
          credit_d = 4'd1;
          tmr_d    = TMO_L;
        end
      end
      CREDIT: begin
        if (refund) begin
          state_d       = CHANGE;
          coin_reject_d = coin;
        end else begin
          grant = found && (credit >= PRICE_L);
          if (coin) begin
            if (credit < MAX_L) cr = credit + 4'd1;
            else                coin_reject_d = 1'b1;
          end
          if (grant) begin
            cr         = cr - PRICE_L;
            state_d    = GRANT;
            disp_req_d = 1'b1;
            disp_id_d  = winner;
            ptr_d      = winner + 2'd1;
          end
          credit_d = cr;
          // Down-counter: the TIMEOUT-th consecutive idle cycle triggers payout.
          if (coin || grant)       tmr_d = TMO_L;
          else if (tmr_q == 8'd1) state_d = CHANGE;
          else                     tmr_d = tmr_q - 8'd1;
        end
      end
      GRANT: begin
        coin_reject_d = coin;
        if (disp_ack) begin
          disp_req_d = 1'b0;
          if (credit != 4'd0) begin
            state_d = CREDIT;
            tmr_d   = TMO_L;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CHANGE: begin
        coin_reject_d = coin;
        if (credit != 4'd0) begin
          change_d = 1'b1;
          credit_d = credit - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      credit      <= '0;
      ptr_q       <= '0;
      tmr_q       <= '0;
      disp_req    <= 1'b0;
      disp_id     <= '0;
      change      <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit      <= credit_d;
      ptr_q       <= ptr_d;
      tmr_q       <= tmr_d;
      disp_req    <= disp_req_d;
      disp_id     <= disp_id_d;
      change      <= change_d;
      coin_reject <= coin_reject_d;
    end
  end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter PRICE, default 3: credit units consumed per vend, range 1..CREDIT_MAX.
REQ-002 Parameter CREDIT_MAX, default 15: credit saturation limit, range 1..15.
REQ-003 Parameter TIMEOUT, default 255: idle cycles in CREDIT before auto-refund, range 1..255.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port coin, input, 1: one-cycle pulse, one credit unit inserted.
REQ-007 Port sel, input, 4: product request levels, bit i = product i.
REQ-008 Port sold_out, input, 4: bit i high masks sel[i].
REQ-009 Port refund, input, 1: one-cycle pulse, return all credit.
REQ-010 Port disp_ack, input, 1: dispenser completion pulse.
REQ-011 Port disp_req, output, 1: dispense request level to the shared dispenser.
REQ-012 Port disp_id, output, 2: product index for the current disp_req.
REQ-013 Port change, output, 1: one-cycle pulse per credit unit returned.
REQ-014 Port coin_reject, output, 1: one-cycle pulse, coin not accepted.
REQ-015 Port credit, output, 4: current credit count.

Function
REQ-016 FSM states SHALL be IDLE, CREDIT, GRANT, CHANGE, all registered.
REQ-017 IDLE: accepted coin -> CREDIT, credit = 1 on the next cycle; sel and refund ignored.
REQ-018 CREDIT: each coin SHALL increment credit by 1 on the next cycle.
REQ-019 A coin at credit == CREDIT_MAX, or in GRANT/CHANGE, SHALL leave credit unchanged and pulse coin_reject on the next cycle.
REQ-020 Eligible requesters: sel[i] & ~sold_out[i], considered only when credit >= PRICE (pre-coin value in that cycle).
REQ-021 Arbitration SHALL be round-robin: search starts at index ptr, ptr reset 0, ptr = winner+1 mod 4 after each grant.
REQ-022 On grant: -> GRANT, disp_req = 1 and disp_id = winner from the next cycle; credit -= PRICE on the same edge.
REQ-023 Coin and eligible sel in the same CREDIT cycle: both take effect (credit + 1 - PRICE).
REQ-024 refund in CREDIT SHALL win over coin and sel in the same cycle -> CHANGE; that coin is rejected.
REQ-025 GRANT: disp_req and disp_id SHALL hold stable until disp_ack sampled high; then disp_req = 0 next cycle.
REQ-026 After disp_ack: credit > 0 -> CREDIT; credit == 0 -> IDLE.
REQ-027 disp_ack outside GRANT SHALL be ignored.
REQ-028 CHANGE: one change pulse per cycle, credit decremented with each pulse; at credit 0 -> IDLE, change = 0 that cycle.
REQ-029 Timeout counter SHALL clear on entry to CREDIT and on any coin or eligible sel; on reaching TIMEOUT -> CHANGE.
REQ-030 sel, refund and timeout SHALL be ignored in GRANT and CHANGE.
REQ-031 credit SHALL never exceed CREDIT_MAX nor underflow.

Reset
REQ-032 rst high SHALL asynchronously force IDLE, credit = 0, ptr = 0, timeout counter = 0, and all outputs 0.
REQ-033 Reset mid-GRANT or mid-CHANGE SHALL abandon the operation: no further disp_req or change pulses, credit lost.
REQ-034 The first state transition SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-035 3 coins, sel = 0010, disp_ack 2 cycles later -> disp_req = 1, disp_id = 1, credit 0, return to IDLE.
REQ-036 5 coins, refund -> CHANGE, exactly 5 change pulses on consecutive cycles, credit 0, IDLE.
REQ-037 16 coins in CREDIT with CREDIT_MAX = 15 -> credit 15, one coin_reject pulse.
REQ-038 credit 6, sel = 1111 held across two vends -> disp_id 0 then 1; sold_out = 0001 -> disp_id 1 first.
REQ-039 2 coins, no activity for 255 cycles -> CHANGE, 2 change pulses, IDLE.
REQ-040 rst asserted in GRANT with disp_req high -> disp_req 0 immediately, credit 0, IDLE after release.
